// File: rtl/rat_pkg.sv
// rat_pkg: shared types and table helpers
// for the checkpointed register alias table.
package rat_pkg;

  localparam int MACHINE_WIDTH = 4;
  localparam int RELEASE_PORTS = 2;
  localparam int TABLE_LEN     = 67;
  localparam int AREG_W        = 7;
  localparam int ROB_W         = 6;
  localparam int CKPT_NUM      = 4;
  localparam int CKPT_W        = $clog2(CKPT_NUM);

  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [ROB_W-1:0]  rob_t;
  typedef logic [CKPT_W-1:0] ckpt_tag_t;

  localparam areg_t HI_IDX    = 7'd65;
  localparam areg_t LO_IDX    = 7'd66;
  localparam areg_t HILO_CODE = 7'd67;

  typedef struct packed {
    logic valid;
    rob_t id;
  } entry_t;

  typedef entry_t [TABLE_LEN-1:0] table_t;

  typedef logic [RELEASE_PORTS-1:0] ret_v_t;
  typedef areg_t [RELEASE_PORTS-1:0] ret_a_t;
  typedef rob_t [RELEASE_PORTS-1:0]  ret_p_t;

  // HI+LO pair code reads back the HI entry
  function automatic entry_t tbl_rd(
    table_t t,
    areg_t  a
  );
    entry_t e;
    e = '0;
    if (a == HILO_CODE) begin
      e = t[HI_IDX];
    end else if (a < HILO_CODE) begin
      e = t[a];
    end
    return e;
  endfunction

  function automatic table_t tbl_wr(
    table_t t,
    areg_t  a,
    rob_t   r
  );
    table_t o;
    o = t;
    if (a == HILO_CODE) begin
      o[HI_IDX] = '{valid: 1'b1, id: r};
      o[LO_IDX] = '{valid: 1'b1, id: r};
    end else if (a != '0 && a < HILO_CODE) begin
      o[a] = '{valid: 1'b1, id: r};
    end
    return o;
  endfunction

  function automatic table_t clr_at(
    table_t t,
    areg_t  a,
    rob_t   p
  );
    table_t o;
    o = t;
    if (o[a].valid && o[a].id == p) begin
      o[a] = '0;
    end
    return o;
  endfunction

  // Retire clears only mappings still owned
  // by the retiring tag.
  function automatic table_t tbl_ret(
    table_t t,
    ret_v_t v,
    ret_a_t d,
    ret_p_t p
  );
    table_t o;
    o = t;
    for (int k = 0; k < RELEASE_PORTS; k++) begin
      if (v[k]) begin
        if (d[k] == HILO_CODE) begin
          o = clr_at(o, HI_IDX, p[k]);
          o = clr_at(o, LO_IDX, p[k]);
        end else if (d[k] < HILO_CODE) begin
          o = clr_at(o, d[k], p[k]);
        end
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/rat_snapshot_bank.sv
// rat_snapshot_bank: branch snapshot slots
// kept current with every retire clear.
module rat_snapshot_bank
  import rat_pkg::*;
(
  input  logic      clk,
  input  logic      resetn,
  input  logic      wr_en,
  input  ckpt_tag_t wr_tag,
  input  table_t    wr_data,
  input  ret_v_t    ret_valid,
  input  ret_a_t    ret_dst,
  input  ret_p_t    ret_preg,
  input  ckpt_tag_t rd_tag,
  output table_t    rd_data
);

  table_t snap_q [CKPT_NUM];

  // Capture new snapshot or age others by retire
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < CKPT_NUM; s++) begin
        snap_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < CKPT_NUM; s++) begin
        if (wr_en && wr_tag == ckpt_tag_t'(s)) begin
          snap_q[s] <= wr_data;
        end else begin
          snap_q[s] <= tbl_ret(snap_q[s],
                               ret_valid,
                               ret_dst,
                               ret_preg);
        end
      end
    end
  end

  assign rd_data = snap_q[rd_tag];

endmodule

// File: rtl/rat_ckpt.sv
// rat_ckpt: register alias table with
// one-cycle branch checkpoint restore.
module rat_ckpt
  import rat_pkg::*;
(
  input  logic   clk,
  input  logic   resetn,
  input  logic   flush,
  input  logic [MACHINE_WIDTH-1:0] ren_valid,
  input  areg_t [MACHINE_WIDTH-1:0] ren_src1,
  input  areg_t [MACHINE_WIDTH-1:0] ren_src2,
  input  areg_t [MACHINE_WIDTH-1:0] ren_dst,
  input  rob_t [MACHINE_WIDTH-1:0] ren_rob,
  input  logic [MACHINE_WIDTH-1:0] ren_br,
  output entry_t [MACHINE_WIDTH-1:0] src1_map,
  output entry_t [MACHINE_WIDTH-1:0] src2_map,
  output entry_t [MACHINE_WIDTH-1:0] dst_old_map,
  output logic   ckpt_ready,
  output ckpt_tag_t ckpt_tag,
  input  ret_v_t ret_valid,
  input  ret_a_t ret_dst,
  input  ret_p_t ret_preg,
  input  logic   br_valid,
  input  ckpt_tag_t br_tag,
  input  logic   br_mispredict
);

  table_t    tbl_q;
  table_t    walk;
  table_t    snap_pre;
  table_t    snap_wr;
  table_t    post;
  table_t    snap_rd;
  table_t    restore;
  logic [CKPT_NUM-1:0] busy_q;
  logic [CKPT_NUM-1:0] busy_nx;
  logic [CKPT_NUM-1:0] busy_mp;
  ckpt_tag_t head_q;
  ckpt_tag_t dh;
  ckpt_tag_t ds;
  logic      mis;
  logic      br_any;
  logic      br_fire;

  assign mis        = br_valid && br_mispredict;
  assign br_any     = |(ren_valid & ren_br);
  assign ckpt_ready = ~busy_q[head_q];
  assign ckpt_tag   = head_q;
  assign br_fire    = br_any && ckpt_ready
                   && !mis && !flush;

  // Write-first rename chain across the lanes
  always_comb begin
    walk        = tbl_q;
    snap_pre    = tbl_q;
    src1_map    = '0;
    src2_map    = '0;
    dst_old_map = '0;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      src1_map[i] = tbl_rd(walk, ren_src1[i]);
      src2_map[i] = tbl_rd(walk, ren_src2[i]);
      if (ren_valid[i]) begin
        walk = tbl_wr(walk, ren_dst[i], ren_rob[i]);
      end
      dst_old_map[i] = tbl_rd(walk, ren_dst[i]);
      if (ren_valid[i] && ren_br[i]) begin
        snap_pre = walk;
      end
    end
  end

  assign snap_wr = tbl_ret(snap_pre, ret_valid,
                           ret_dst, ret_preg);
  assign post    = tbl_ret(walk, ret_valid,
                           ret_dst, ret_preg);
  assign restore = tbl_ret(snap_rd, ret_valid,
                           ret_dst, ret_preg);

  rat_snapshot_bank u_bank (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en     (br_fire),
    .wr_tag    (head_q),
    .wr_data   (snap_wr),
    .ret_valid (ret_valid),
    .ret_dst   (ret_dst),
    .ret_preg  (ret_preg),
    .rd_tag    (br_tag),
    .rd_data   (snap_rd)
  );

  // Busy update for resolve and allocation
  always_comb begin
    busy_nx = busy_q;
    if (br_valid && !br_mispredict) begin
      busy_nx[br_tag] = 1'b0;
    end
    if (br_fire) begin
      busy_nx[head_q] = 1'b1;
    end
  end

  // Squash the mispredicted slot and all younger
  always_comb begin
    busy_mp = busy_q;
    dh      = head_q - br_tag;
    ds      = '0;
    for (int s = 0; s < CKPT_NUM; s++) begin
      ds = ckpt_tag_t'(s) - br_tag;
      if (dh == '0 || ds < dh) begin
        busy_mp[s] = 1'b0;
      end
    end
  end

  // Live table, busy vector and head pointer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tbl_q  <= '0;
      busy_q <= '0;
      head_q <= '0;
    end else if (flush) begin
      tbl_q  <= '0;
      busy_q <= '0;
      head_q <= '0;
    end else if (mis) begin
      tbl_q  <= restore;
      busy_q <= busy_mp;
      head_q <= br_tag;
    end else begin
      tbl_q  <= post;
      busy_q <= busy_nx;
      if (br_fire) begin
        head_q <= ckpt_tag_t'(head_q + 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_rat_ckpt.sv
// tb_rat_ckpt: directed scoreboard bench
// for the checkpointed alias table.
module tb_rat_ckpt;
  import rat_pkg::*;

  localparam int MW = MACHINE_WIDTH;
  localparam int RP = RELEASE_PORTS;

  logic clk = 1'b0;
  logic resetn;
  logic flush;
  logic [MW-1:0] ren_valid;
  areg_t [MW-1:0] ren_src1;
  areg_t [MW-1:0] ren_src2;
  areg_t [MW-1:0] ren_dst;
  rob_t [MW-1:0] ren_rob;
  logic [MW-1:0] ren_br;
  entry_t [MW-1:0] src1_map;
  entry_t [MW-1:0] src2_map;
  entry_t [MW-1:0] dst_old_map;
  logic ckpt_ready;
  ckpt_tag_t ckpt_tag;
  ret_v_t ret_valid;
  ret_a_t ret_dst;
  ret_p_t ret_preg;
  logic br_valid;
  ckpt_tag_t br_tag;
  logic br_mispredict;

  rat_ckpt dut (
    .clk           (clk),
    .resetn        (resetn),
    .flush         (flush),
    .ren_valid     (ren_valid),
    .ren_src1      (ren_src1),
    .ren_src2      (ren_src2),
    .ren_dst       (ren_dst),
    .ren_rob       (ren_rob),
    .ren_br        (ren_br),
    .src1_map      (src1_map),
    .src2_map      (src2_map),
    .dst_old_map   (dst_old_map),
    .ckpt_ready    (ckpt_ready),
    .ckpt_tag      (ckpt_tag),
    .ret_valid     (ret_valid),
    .ret_dst       (ret_dst),
    .ret_preg      (ret_preg),
    .br_valid      (br_valid),
    .br_tag        (br_tag),
    .br_mispredict (br_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    int         k;
    int         ln;
    logic [6:0] v;
  } exp_t;

  exp_t q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  localparam int K_S1  = 0;
  localparam int K_S2  = 1;
  localparam int K_DO  = 2;
  localparam int K_RDY = 3;
  localparam int K_TAG = 4;

  function automatic logic [6:0] E(bit v, int id);
    return {v, 6'(id)};
  endfunction

  task automatic clr();
    flush         = 1'b0;
    ren_valid     = '0;
    ren_src1      = '0;
    ren_src2      = '0;
    ren_dst       = '0;
    ren_rob       = '0;
    ren_br        = '0;
    ret_valid     = '0;
    ret_dst       = '0;
    ret_preg      = '0;
    br_valid      = 1'b0;
    br_tag        = '0;
    br_mispredict = 1'b0;
  endtask

  task automatic ex(string nm, int k, int ln,
                    logic [6:0] v);
    exp_t e;
    e.nm = nm;
    e.k  = k;
    e.ln = ln;
    e.v  = v;
    q.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic wr(int ln, int d, int r, bit b);
    ren_valid[ln] = 1'b1;
    ren_dst[ln]   = 7'(d);
    ren_rob[ln]   = 6'(r);
    ren_br[ln]    = b;
  endtask

  task automatic rd(int ln, int a, int b);
    ren_src1[ln] = 7'(a);
    ren_src2[ln] = 7'(b);
  endtask

  task automatic ret(int p, int d, int r);
    ret_valid[p] = 1'b1;
    ret_dst[p]   = 7'(d);
    ret_preg[p]  = 6'(r);
  endtask

  task automatic res(int t, bit m);
    br_valid      = 1'b1;
    br_tag        = 2'(t);
    br_mispredict = m;
  endtask

  // Monitor: compare queued expectations
  initial begin
    exp_t e;
    logic [6:0] a;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        a = '0;
        case (e.k)
          K_S1:  a = src1_map[e.ln];
          K_S2:  a = src2_map[e.ln];
          K_DO:  a = dst_old_map[e.ln];
          K_RDY: a = {6'b0, ckpt_ready};
          default: a = {5'b0, ckpt_tag};
        endcase
        n_run++;
        if (a !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %h want %h",
                   e.nm, a, e.v);
        end
      end
    end
  end

  // Branch-tag protocol watch
  logic [CKPT_NUM-1:0] mb;
  ckpt_tag_t mh;
  ckpt_tag_t mt;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mb = '0;
      mh = '0;
    end else begin
      if (br_valid)
        assert (mb[br_tag])
          else $error("FAIL protocol tag %0d",
                      br_tag);
      if (flush) begin
        mb = '0;
        mh = '0;
      end else if (br_valid && br_mispredict) begin
        mt = br_tag;
        do begin
          mb[mt] = 1'b0;
          mt = mt + 1'b1;
        end while (mt != mh);
        mh = br_tag;
      end else begin
        if (br_valid) mb[br_tag] = 1'b0;
        if (|(ren_valid & ren_br)) begin
          mb[mh] = 1'b1;
          mh = mh + 1'b1;
        end
      end
    end
  end

  initial begin
    clr();
    resetn = 1'b0;
    rd(0, 3, 0);
    ex("rst_ready", K_RDY, 0, 7'd1);
    ex("rst_tag", K_TAG, 0, 7'd0);
    ex("rst_r3", K_S1, 0, E(0, 0));
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    clr();

    // write-first within group
    wr(0, 3, 5, 0);
    wr(1, 3, 6, 0);
    rd(1, 3, 0);
    rd(2, 3, 0);
    ex("wf_l1_src", K_S1, 1, E(1, 5));
    ex("wf_l2_src", K_S1, 2, E(1, 6));
    ex("wf_l0_old", K_DO, 0, E(1, 5));
    ex("wf_l1_old", K_DO, 1, E(1, 6));
    nxt();
    rd(0, 3, 0);
    ex("wf_r3_next", K_S1, 0, E(1, 6));
    nxt();

    // HI/LO pair write and retire
    wr(0, 67, 9, 0);
    ex("hilo_old", K_DO, 0, E(1, 9));
    nxt();
    rd(0, 65, 66);
    ret(0, 67, 8);
    ex("hilo_hi", K_S1, 0, E(1, 9));
    ex("hilo_lo", K_S2, 0, E(1, 9));
    nxt();
    rd(0, 65, 66);
    ret(1, 67, 9);
    ex("ret_nomatch_hi", K_S1, 0, E(1, 9));
    ex("ret_nomatch_lo", K_S2, 0, E(1, 9));
    nxt();
    rd(0, 65, 66);
    ex("ret_hi_clr", K_S1, 0, E(0, 0));
    ex("ret_lo_clr", K_S2, 0, E(0, 0));
    nxt();

    // checkpoint mid-group, mispredict
    wr(0, 4, 2, 0);
    wr(1, 0, 0, 1);
    wr(2, 4, 7, 0);
    ex("br1_tag", K_TAG, 0, 7'd0);
    ex("br1_ready", K_RDY, 0, 7'd1);
    ex("br1_old_l2", K_DO, 2, E(1, 7));
    nxt();
    res(0, 1);
    rd(0, 4, 0);
    wr(1, 4, 20, 0);
    ex("mp1_pre_r4", K_S1, 0, E(1, 7));
    ex("mp1_pre_tag", K_TAG, 0, 7'd1);
    nxt();
    rd(0, 4, 0);
    ex("mp1_r4", K_S1, 0, E(1, 2));
    ex("mp1_tag", K_TAG, 0, 7'd0);
    ex("mp1_ready", K_RDY, 0, 7'd1);
    nxt();

    // retire also clears snapshot
    wr(0, 5, 3, 1);
    ex("br2_tag", K_TAG, 0, 7'd0);
    nxt();
    ret(0, 5, 3);
    rd(0, 5, 0);
    ex("br2_r5", K_S1, 0, E(1, 3));
    nxt();
    wr(0, 5, 11, 0);
    rd(0, 5, 0);
    ex("br2_r5_clr", K_S1, 0, E(0, 0));
    nxt();
    res(0, 1);
    rd(0, 5, 0);
    ex("br2_r5_new", K_S1, 0, E(1, 11));
    nxt();
    rd(0, 5, 0);
    ex("br2_restore", K_S1, 0, E(0, 0));
    ex("br2_tag_back", K_TAG, 0, 7'd0);
    nxt();

    // fill all slots, resolve, squash
    wr(0, 0, 0, 1);
    ex("fill_t0", K_TAG, 0, 7'd0);
    nxt();
    wr(0, 6, 12, 1);
    ex("fill_t1", K_TAG, 0, 7'd1);
    nxt();
    wr(0, 6, 13, 1);
    ex("fill_t2", K_TAG, 0, 7'd2);
    nxt();
    wr(0, 0, 0, 1);
    ex("fill_t3", K_TAG, 0, 7'd3);
    ex("fill_rdy3", K_RDY, 0, 7'd1);
    nxt();
    rd(0, 6, 0);
    res(0, 0);
    ex("full_ready", K_RDY, 0, 7'd0);
    ex("full_wrap", K_TAG, 0, 7'd0);
    ex("full_r6", K_S1, 0, E(1, 13));
    nxt();
    res(1, 1);
    ex("res0_ready", K_RDY, 0, 7'd1);
    ex("res0_tag", K_TAG, 0, 7'd0);
    nxt();
    rd(0, 6, 0);
    wr(1, 0, 0, 1);
    ex("sq_r6", K_S1, 0, E(1, 12));
    ex("sq_head", K_TAG, 0, 7'd1);
    ex("sq_ready", K_RDY, 0, 7'd1);
    nxt();
    wr(0, 0, 0, 1);
    ex("sq_free2", K_TAG, 0, 7'd2);
    ex("sq_rdy2", K_RDY, 0, 7'd1);
    nxt();
    wr(0, 0, 0, 1);
    ex("sq_free3", K_TAG, 0, 7'd3);
    ex("sq_rdy3", K_RDY, 0, 7'd1);
    nxt();
    wr(0, 0, 0, 1);
    ex("sq_free0", K_TAG, 0, 7'd0);
    ex("sq_rdy0", K_RDY, 0, 7'd1);
    nxt();

    // flush beats same-cycle mispredict
    flush = 1'b1;
    res(2, 1);
    wr(0, 7, 4, 0);
    ex("full2_ready", K_RDY, 0, 7'd0);
    ex("full2_tag", K_TAG, 0, 7'd1);
    nxt();
    rd(0, 6, 7);
    ex("fl_ready", K_RDY, 0, 7'd1);
    ex("fl_tag", K_TAG, 0, 7'd0);
    ex("fl_r6", K_S1, 0, E(0, 0));
    ex("fl_r7", K_S2, 0, E(0, 0));
    nxt();

    // asynchronous reset mid-stream
    wr(0, 8, 5, 1);
    ex("pre_rst_tag", K_TAG, 0, 7'd0);
    nxt();
    rd(0, 8, 0);
    ex("pre_rst_r8", K_S1, 0, E(1, 5));
    ex("pre_rst_head", K_TAG, 0, 7'd1);
    nxt();
    rd(0, 8, 0);
    #1;
    resetn = 1'b0;
    ex("arst_r8", K_S1, 0, E(0, 0));
    ex("arst_tag", K_TAG, 0, 7'd0);
    ex("arst_ready", K_RDY, 0, 7'd1);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    clr();
    rd(0, 8, 0);
    ex("post_rst_r8", K_S1, 0, E(0, 0));
    ex("post_rst_tag", K_TAG, 0, 7'd0);
    nxt();

    @(negedge clk);
    #1;
    n_run++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d want 0",
               q.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
